// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory / MMIO slave: register offsets,
// STATUS bit positions and the address-region decode enum.
package dmem_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

endpackage

// File: rtl/dmem_mmio_if.sv
// CPU data port plus transmit-sink handshake, bundled for the dmem_mmio slave.
interface dmem_mmio_if;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (output daddr, dwdata, we, tx_ready,
                    input  drdata, tx_data, tx_valid);
    modport slave  (input  daddr, dwdata, we, tx_ready,
                    output drdata, tx_data, tx_valid);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head output; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge, otherwise it is dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             drop
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    assign count_next  = count_reg + CW'(do_push) - CW'(do_pop);
    // The byte being written this edge may become the new head (push into empty).
    assign head_next   = (do_push && (wr_ptr_reg == rd_ptr_next)) ? din : mem[rd_ptr_next];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (count_next != '0) head_reg <= head_next;
        end
    end

    assign dout  = head_reg;
    assign count = count_reg;
endmodule

// File: rtl/dmem_mmio.sv
// Word RAM with byte-lane writes plus a 16-byte MMIO window (TX FIFO, STATUS, CYCLE).
// Define DMEM_CYCLE_COUNTER_EN to implement the free-running CYCLE counter.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input logic        clk,
    input logic        reset,
    dmem_mmio_if.slave bus
);
    localparam int          RAW       = $clog2(DEPTH_WORDS);
    localparam int          FCW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    region_e     region;
    logic [1:0]  off;
    logic [RAW-1:0] ram_idx;
    logic [31:0] wmask, status, cycle, rdata;
    logic        ram_we, push, ovf_clr, drop, full, empty, ovf_reg;
    logic [FCW-1:0] fifo_count;
    logic [31:0] ram [DEPTH_WORDS];

    always_comb begin
        if (bus.daddr < RAM_BYTES)                    region = REG_RAM;
        else if (bus.daddr[31:4] == MMIO_BASE[31:4])  region = REG_MMIO;
        else                                          region = REG_NONE;
    end

    assign off     = bus.daddr[3:2];
    assign ram_idx = bus.daddr[RAW+1:2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wmask[8*gi +: 8] = {8{bus.we[gi]}};
    end

    assign ram_we  = (region == REG_RAM) && (bus.we != 4'b0000);
    assign push    = (region == REG_MMIO) && (off == OFF_TXDATA) && bus.we[0];
    assign ovf_clr = (region == REG_MMIO) && (off == OFF_STATUS) && bus.we[0] && bus.dwdata[ST_OVF];

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= (ram[ram_idx] & ~wmask) | (bus.dwdata & wmask);
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.dwdata[7:0]),
        .pop   (bus.tx_valid && bus.tx_ready),
        .dout  (bus.tx_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count),
        .drop  (drop)
    );

    assign bus.tx_valid = !empty;

    // A new overflow on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ovf_reg <= 1'b0;
        else if (drop)    ovf_reg <= 1'b1;
        else if (ovf_clr) ovf_reg <= 1'b0;
    end

    always_comb begin
        status = '0;
        status[ST_CNT_LSB +: 4] = 4'(fifo_count);
        status[ST_OVF]          = ovf_reg;
        status[ST_EMPTY]        = empty;
        status[ST_FULL]         = full;
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_reg <= '0;
        else       cycle_reg <= cycle_reg + 32'd1;
    end
    assign cycle = cycle_reg;
`else
    assign cycle = '0;
`endif

    always_comb begin
        rdata = '0;
        case (region)
            REG_RAM:  rdata = ram[ram_idx];
            REG_MMIO: begin
                case (off)
                    OFF_STATUS: rdata = status;
                    OFF_CYCLE:  rdata = cycle;
                    default:    rdata = '0;
                endcase
            end
            default:  rdata = '0;
        endcase
    end

    assign bus.drdata = rdata;
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM lanes, decode, TX FIFO scoreboard, CYCLE and reset.
module tb_dmem_mmio;
    localparam int          DW = 1024;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_mmio_if bus ();

    dmem_mmio #(.DEPTH_WORDS(DW), .FIFO_DEPTH(8), .MMIO_BASE(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;
    logic [7:0] sb [$];
    logic [7:0] last_tx = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] lanes);
        bus.daddr  = addr;
        bus.dwdata = data;
        bus.we     = lanes;
        $display("WR addr=%08h data=%08h we=%b", addr, data, lanes);
        tick();
        bus.we = 4'b0000;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.daddr = addr;
        bus.we    = 4'b0000;
        #1;
        $display("RD addr=%08h data=%08h", addr, bus.drdata);
        check(tag, bus.drdata, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit accept;
        accept = (sb.size() < 8) || (bus.tx_valid && bus.tx_ready);
        if (accept) sb.push_back(b);
        wr(MB, {24'h0, b}, 4'b0001);
    endtask

    task automatic drain(input string tag, input int exp_clks);
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp_clks));
    endtask

    // Each handshake seen before a rising edge must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.tx_valid && bus.tx_ready) begin
            if (sb.size() == 0) begin
                total++;
                failed++;
                $error("FAIL tx_unexpected: observed %02h expected no byte", bus.tx_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                $display("TX byte=%02h", bus.tx_data);
                last_tx = bus.tx_data;
                check("tx_order", {24'h0, bus.tx_data}, {24'h0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c1, c2;
        bus.daddr = '0; bus.dwdata = '0; bus.we = '0; bus.tx_ready = 1'b0;
        #2;
        check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        rd_check("rst_status", MB + 32'h4, 32'h0000_0002);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // RAM lanes and decode
        wr(32'h0, 32'hCAFE_F00D, 4'hF);
        wr(32'h10, 32'h1122_3344, 4'hF);
        wr(32'h10, 32'h00AA_0000, 4'b0100);
        rd_check("ram_lane", 32'h10, 32'h11AA_3344);
        wr(32'h14, 32'hAABB_CCDD, 4'hF);
        wr(32'h14, 32'h0000_0000, 4'h0);
        rd_check("ram_we0", 32'h14, 32'hAABB_CCDD);
        wr(32'hFFC, 32'h1357_9BDF, 4'hF);
        rd_check("ram_top", 32'hFFC, 32'h1357_9BDF);
        wr(32'(DW * 4), 32'hDEAD_BEEF, 4'hF);
        rd_check("oor_read", 32'(DW * 4), 32'h0);
        rd_check("oor_word0", 32'h0, 32'hCAFE_F00D);
        wr(32'h8000_0000, 32'h1234_5678, 4'hF);
        rd_check("unmapped", 32'h8000_0000, 32'h0);
        rd_check("mmio_txdata_rd", MB, 32'h0);
        tick();
        rd_check("mmio_off_c", MB + 32'hC, 32'h0);

        // CYCLE counter
        tick();
        bus.daddr = MB + 32'h8; #1; c1 = bus.drdata;
        repeat (5) tick();
        bus.daddr = MB + 32'h8; #1; c2 = bus.drdata;
`ifdef DMEM_CYCLE_COUNTER_EN
        check("cycle_delta", c2 - c1, 32'd5);
`else
        check("cycle_off_a", c1, 32'h0);
        check("cycle_off_b", c2, 32'h0);
`endif

        // FIFO fill with overflow, clear, drain
        tick();
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        rd_check("fill_status", MB + 32'h4, 32'h0000_0085);
        check("fill_head", {24'h0, bus.tx_data}, 32'h01);
        wr(MB + 32'h4, 32'h0000_0004, 4'b0001);
        rd_check("ovf_clear", MB + 32'h4, 32'h0000_0081);
        check("head_hold", {24'h0, bus.tx_data}, 32'h01);
        bus.tx_ready = 1'b1;
        drain("drain_clks", 8);
        bus.tx_ready = 1'b0;
        check("drained_valid", {31'h0, bus.tx_valid}, 32'h0);
        rd_check("drained_status", MB + 32'h4, 32'h0000_0002);

        // Push and pop on the same edge while full
        tick();
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        rd_check("full_status", MB + 32'h4, 32'h0000_0081);
        bus.tx_ready = 1'b1;
        push_byte(8'h5A);
        rd_check("simul_status", MB + 32'h4, 32'h0000_0081);
        drain("simul_drain", 8);
        check("simul_last", {24'h0, last_tx}, 32'h5A);
        bus.tx_ready = 1'b0;

        // Reset in the middle of traffic
        tick();
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        check("pre_rst_valid", {31'h0, bus.tx_valid}, 32'h1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'h0, bus.tx_valid}, 32'h0);
        sb.delete();
        rd_check("midrst_status", MB + 32'h4, 32'h0000_0002);
        rd_check("midrst_cycle", MB + 32'h8, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
`ifdef DMEM_CYCLE_COUNTER_EN
        rd_check("cycle_restart", MB + 32'h8, 32'd3);
`else
        rd_check("cycle_restart", MB + 32'h8, 32'd0);
`endif
        rd_check("ram_after_rst", 32'h10, 32'h11AA_3344);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
